// File: rtl/i2lbs_database_arbiter.sv
// Round-robin arbiter that shares one classifier database ROM between NUM_REQ stage evaluators.
// One read is issued per cycle, and a one-hot tag pipeline routes each returned word to its requester.
module i2lbs_database_arbiter #(
  parameter int NUM_REQ      = 25,
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 16,
  parameter int READ_LATENCY = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic [NUM_REQ-1:0]            o_gnt,
  output logic                          o_mem_ren,
  output logic [ADDR_WIDTH-1:0]         o_mem_addr,
  output logic [DATA_WIDTH-1:0]         o_rdata,
  output logic [NUM_REQ-1:0]            o_rvalid,
  output logic                          o_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  ren_q, ren_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [NUM_REQ-1:0]    tag_q [READ_LATENCY+1];
  logic [NUM_REQ-1:0]    tag_d [READ_LATENCY+1];

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [NUM_REQ-1:0]    eligible;
  logic                  found;
  logic [PTR_W-1:0]      win_idx;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [PTR_W-1:0]      cand_idx;
  logic                  tag_any;
  int                    cand;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  // Search starts one past the last winner, so the last winner is visited last.
  always_comb begin
    eligible = req & ~gnt_q & {NUM_REQ{enable}};
    found    = 1'b0;
    win_idx  = '0;
    win_addr = '0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = PTR_W'(cand);
      if (!found && eligible[cand_idx]) begin
        found    = 1'b1;
        win_idx  = cand_idx;
        win_addr = addr_arr[cand_idx];
      end
    end
  end

  always_comb begin
    gnt_d  = '0;
    ren_d  = found;
    addr_d = addr_q;
    ptr_d  = ptr_q;
    if (found) begin
      gnt_d          = '0;
      gnt_d[win_idx] = 1'b1;
      addr_d         = win_addr;
      ptr_d          = win_idx;
    end
    tag_d[0] = ren_q ? gnt_q : '0;
    for (int i = 1; i <= READ_LATENCY; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    // mem_rdata is valid while the tag sits one stage before the output.
    rdata_d = (|tag_q[READ_LATENCY-1]) ? mem_rdata : rdata_q;
    tag_any = 1'b0;
    for (int i = 0; i <= READ_LATENCY; i++) begin
      tag_any = tag_any | (|tag_q[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      gnt_q   <= '0;
      ren_q   <= 1'b0;
      addr_q  <= '0;
      rdata_q <= '0;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ren_q   <= ren_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      for (int i = 0; i <= READ_LATENCY; i++) begin
        tag_q[i] <= tag_d[i];
      end
    end
  end

  assign o_gnt      = gnt_q;
  assign o_mem_ren  = ren_q;
  assign o_mem_addr = addr_q;
  assign o_rdata    = rdata_q;
  assign o_rvalid   = tag_q[READ_LATENCY];
  assign o_busy     = (|req) | ren_q | tag_any;

endmodule

// File: tb/tb_i2lbs_database_arbiter.sv
// Bench for i2lbs_database_arbiter: scenario tasks check grants inline; a negedge monitor
// pops the expected-return queue on every o_rvalid and checks one-hot outputs.
module tb_i2lbs_database_arbiter;
  localparam int N  = 25;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RL = 2;

  logic            clk;
  logic            reset;
  logic            enable;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [DW-1:0]   mem_rdata;
  logic [N-1:0]    o_gnt;
  logic            o_mem_ren;
  logic [AW-1:0]   o_mem_addr;
  logic [DW-1:0]   o_rdata;
  logic [N-1:0]    o_rvalid;
  logic            o_busy;

  int n_checks = 0;
  int n_fail   = 0;

  // {stage index, data word}
  logic [20:0] exp_q[$];

  i2lbs_database_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req), .req_addr(req_addr),
    .mem_rdata(mem_rdata), .o_gnt(o_gnt), .o_mem_ren(o_mem_ren), .o_mem_addr(o_mem_addr),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_busy(o_busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    return (a == 12'h05A) ? 16'hBEEF : {4'hA ^ a[3:0], a};
  endfunction

  // ROM model: data appears RL cycles after the read enable.
  logic [DW-1:0] rom_pipe [RL];
  always @(posedge clk) begin
    rom_pipe[0] <= o_mem_ren ? rom_word(o_mem_addr) : 16'hDEAD;
    for (int i = 1; i < RL; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign mem_rdata = rom_pipe[RL-1];

  // scoreboard monitor
  always @(negedge clk) begin
    logic [20:0]  e;
    logic [N-1:0] exp_v;
    if (!reset) begin
      n_checks++;
      if (!$onehot0(o_gnt)) begin
        n_fail++; $display("FAIL gnt_onehot: got %h expected one-hot or zero", o_gnt);
      end
      n_checks++;
      if (!$onehot0(o_rvalid)) begin
        n_fail++; $display("FAIL rvalid_onehot: got %h expected one-hot or zero", o_rvalid);
      end
      if (o_rvalid !== '0) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rvalid_unexpected: got %h expected no return", o_rvalid);
        end else begin
          e = exp_q.pop_front();
          exp_v = '0;
          exp_v[e[20:16]] = 1'b1;
          if (o_rvalid !== exp_v || o_rdata !== e[15:0]) begin
            n_fail++;
            $display("FAIL return: got rvalid=%h rdata=%h expected rvalid=%h rdata=%h",
                     o_rvalid, o_rdata, exp_v, e[15:0]);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a);
    req[i] = v;
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic push_exp(input int i, input logic [AW-1:0] a);
    exp_q.push_back({5'(i), rom_word(a)});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b1;
    req = '0;
    req_addr = '0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget;
    budget = 30;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(); budget--;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL %s_drain: got %0d pending expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req = '0; req_addr = '0;
    @(posedge clk); #1;
    n_checks++;
    if ({o_gnt, o_mem_ren, o_mem_addr, o_rdata, o_rvalid, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%h ren=%b addr=%h rdata=%h rvalid=%h busy=%b expected all 0",
               o_gnt, o_mem_ren, o_mem_addr, o_rdata, o_rvalid, o_busy);
    end
    @(posedge clk); #1 reset = 1'b0;
    sample();
    n_checks++;
    if (o_gnt !== '0 || o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got gnt=%h busy=%b expected 0 0", o_gnt, o_busy);
    end
  endtask

  task automatic test_single_read();
    logic [N-1:0] exp_v;
    do_reset();
    set_req(3, 1'b1, 12'h05A);
    push_exp(3, 12'h05A);
    tick(); req[3] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1 << 3) || o_mem_ren !== 1'b1 || o_mem_addr !== 12'h05A) begin
      n_fail++;
      $display("FAIL single_grant: got gnt=%h ren=%b addr=%h expected gnt=%h ren=1 addr=05a",
               o_gnt, o_mem_ren, o_mem_addr, N'(1 << 3));
    end
    for (int c = 2; c <= 4; c++) begin
      tick(); sample();
      exp_v = (c == 4) ? N'(1 << 3) : '0;
      n_checks++;
      if (o_rvalid !== exp_v || (c == 4 && o_rdata !== 16'hBEEF)) begin
        n_fail++;
        $display("FAIL single_return_c%0d: got rvalid=%h rdata=%h expected rvalid=%h rdata=beef",
                 c, o_rvalid, o_rdata, exp_v);
      end
    end
    wait_drain("single");
  endtask

  task automatic test_all_requests();
    logic [N-1:0] exp_g;
    int idx;
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i));
    for (int c = 0; c <= N; c++) push_exp(c % N, AW'(c % N));
    for (int c = 1; c <= N + 1; c++) begin
      tick();
      if (c == N + 1) req = '0;
      sample();
      idx = (c - 1) % N;
      exp_g = '0; exp_g[idx] = 1'b1;
      n_checks++;
      if (o_gnt !== exp_g || o_mem_addr !== AW'(idx) || o_mem_ren !== 1'b1) begin
        n_fail++;
        $display("FAIL all_grant_c%0d: got gnt=%h addr=%h expected gnt=%h addr=%h",
                 c, o_gnt, o_mem_addr, exp_g, AW'(idx));
      end
    end
    tick(); sample();
    n_checks++;
    if (o_gnt !== '0) begin
      n_fail++; $display("FAIL all_stop: got gnt=%h expected 0", o_gnt);
    end
    wait_drain("all");
  endtask

  task automatic test_lone_requester();
    logic [N-1:0] exp_g;
    do_reset();
    set_req(5, 1'b1, 12'h123);
    for (int k = 0; k < 5; k++) push_exp(5, 12'h123);
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (c == 10) req[5] = 1'b0;
      sample();
      exp_g = (c % 2 == 1) ? N'(1 << 5) : '0;
      n_checks++;
      if (o_gnt !== exp_g) begin
        n_fail++; $display("FAIL lone_c%0d: got gnt=%h expected %h", c, o_gnt, exp_g);
      end
    end
    tick(); sample();
    n_checks++;
    if (o_gnt !== '0) begin
      n_fail++; $display("FAIL lone_stop: got gnt=%h expected 0", o_gnt);
    end
    wait_drain("lone");
  endtask

  task automatic test_pointer_wrap();
    do_reset();
    set_req(10, 1'b1, 12'h0AA);
    push_exp(10, 12'h0AA);
    tick(); req[10] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1 << 10)) begin
      n_fail++; $display("FAIL wrap_setup: got gnt=%h expected %h", o_gnt, N'(1 << 10));
    end
    tick();
    set_req(2, 1'b1, 12'h222);
    set_req(20, 1'b1, 12'h314);
    push_exp(20, 12'h314);
    push_exp(2, 12'h222);
    tick(); req[20] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1 << 20) || o_mem_addr !== 12'h314) begin
      n_fail++; $display("FAIL wrap_first: got gnt=%h addr=%h expected %h 314", o_gnt, o_mem_addr, N'(1 << 20));
    end
    tick(); req[2] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1 << 2) || o_mem_addr !== 12'h222) begin
      n_fail++; $display("FAIL wrap_second: got gnt=%h addr=%h expected %h 222", o_gnt, o_mem_addr, N'(1 << 2));
    end
    tick(); sample();
    n_checks++;
    if (o_gnt !== '0) begin
      n_fail++; $display("FAIL wrap_stop: got gnt=%h expected 0", o_gnt);
    end
    wait_drain("wrap");
  endtask

  task automatic test_enable_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) set_req(i, 1'b1, AW'(12'h100 + i));
    for (int i = 1; i <= 3; i++) push_exp(i, AW'(12'h100 + i));
    for (int c = 1; c <= 3; c++) begin
      tick();
      req[c] = 1'b0;
      if (c == 3) enable = 1'b0;
      sample();
      n_checks++;
      if (o_gnt !== N'(1 << c)) begin
        n_fail++; $display("FAIL en_grant_c%0d: got gnt=%h expected %h", c, o_gnt, N'(1 << c));
      end
    end
    for (int c = 4; c <= 10; c++) begin
      tick(); sample();
      n_checks++;
      if (o_gnt !== '0 || o_busy !== 1'b1) begin
        n_fail++; $display("FAIL en_blocked_c%0d: got gnt=%h busy=%b expected 0 1", c, o_gnt, o_busy);
      end
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL en_returns: got %0d pending expected 0", exp_q.size());
    end
    tick(); req[4] = 1'b0; sample();
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL en_busy_low: got busy=%b expected 0", o_busy);
    end
    tick();
    enable = 1'b1;
    set_req(0, 1'b1, 12'h100);
    set_req(4, 1'b1, 12'h104);
    push_exp(4, 12'h104);
    push_exp(0, 12'h100);
    tick(); req[4] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1 << 4)) begin
      n_fail++; $display("FAIL en_resume_first: got gnt=%h expected %h", o_gnt, N'(1 << 4));
    end
    tick(); req[0] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1)) begin
      n_fail++; $display("FAIL en_resume_second: got gnt=%h expected %h", o_gnt, N'(1));
    end
    wait_drain("en");
  endtask

  task automatic test_reset_mid_flight();
    do_reset();
    set_req(1, 1'b1, 12'h011);
    set_req(2, 1'b1, 12'h022);
    push_exp(1, 12'h011);
    push_exp(2, 12'h022);
    tick(); req[1] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1 << 1)) begin
      n_fail++; $display("FAIL mid_grant1: got gnt=%h expected %h", o_gnt, N'(1 << 1));
    end
    tick(); req[2] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1 << 2)) begin
      n_fail++; $display("FAIL mid_grant2: got gnt=%h expected %h", o_gnt, N'(1 << 2));
    end
    tick();
    reset = 1'b1;
    exp_q.delete();
    #1;
    n_checks++;
    if ({o_gnt, o_mem_ren, o_mem_addr, o_rdata, o_rvalid, o_busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got gnt=%h ren=%b addr=%h rdata=%h rvalid=%h busy=%b expected all 0",
               o_gnt, o_mem_ren, o_mem_addr, o_rdata, o_rvalid, o_busy);
    end
    tick(); tick();
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick(); sample();
      n_checks++;
      if (o_rvalid !== '0) begin
        n_fail++; $display("FAIL mid_stale_c%0d: got rvalid=%h expected 0", c, o_rvalid);
      end
    end
    tick();
    set_req(0, 1'b1, 12'h0F0);
    set_req(7, 1'b1, 12'h077);
    push_exp(0, 12'h0F0);
    push_exp(7, 12'h077);
    tick(); req[0] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1)) begin
      n_fail++; $display("FAIL mid_after_first: got gnt=%h expected %h", o_gnt, N'(1));
    end
    tick(); req[7] = 1'b0; sample();
    n_checks++;
    if (o_gnt !== N'(1 << 7)) begin
      n_fail++; $display("FAIL mid_after_second: got gnt=%h expected %h", o_gnt, N'(1 << 7));
    end
    wait_drain("mid");
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_all_requests();
    test_lone_requester();
    test_pointer_wrap();
    test_enable_drain();
    test_reset_mid_flight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
